// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low glyph codes in {g,f,e,d,c,b,a} order
// plus the nibble-to-glyph decode used by every display block.
package seg7_pkg;

    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_A     = 7'h08;
    localparam logic [6:0] SEG_B     = 7'h03;
    localparam logic [6:0] SEG_C     = 7'h46;
    localparam logic [6:0] SEG_D     = 7'h21;
    localparam logic [6:0] SEG_E     = 7'h06;
    localparam logic [6:0] SEG_F     = 7'h0E;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    function automatic logic [6:0] seg7_decode(input logic [3:0] nibble);
        logic [6:0] glyph;
        case (nibble)
            4'h0:    glyph = SEG_0;
            4'h1:    glyph = SEG_1;
            4'h2:    glyph = SEG_2;
            4'h3:    glyph = SEG_3;
            4'h4:    glyph = SEG_4;
            4'h5:    glyph = SEG_5;
            4'h6:    glyph = SEG_6;
            4'h7:    glyph = SEG_7;
            4'h8:    glyph = SEG_8;
            4'h9:    glyph = SEG_9;
            4'hA:    glyph = SEG_A;
            4'hB:    glyph = SEG_B;
            4'hC:    glyph = SEG_C;
            4'hD:    glyph = SEG_D;
            4'hE:    glyph = SEG_E;
            4'hF:    glyph = SEG_F;
            default: glyph = SEG_BLANK;
        endcase
        return glyph;
    endfunction

endpackage

// File: rtl/seg7_hex_decode.sv
// Combinational single-digit decoder; in decimal mode nibbles above 9 are
// reported as blank so the caller can also suppress the decimal point.
module seg7_hex_decode
    import seg7_pkg::*;
(
    input  logic [3:0] nibble,
    input  logic       hex_mode,
    output logic [6:0] seg,
    output logic       blank
);

    // Glyph lookup with decimal-mode suppression
    always_comb begin
        blank = 1'b0;
        seg   = SEG_BLANK;
        if (!hex_mode && (nibble > 4'd9)) begin
            blank = 1'b1;
            seg   = SEG_BLANK;
        end else begin
            blank = 1'b0;
            seg   = seg7_decode(nibble);
        end
    end

endmodule

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed N-digit 7-segment driver: double-buffered value, per-digit
// dp/blink, leading-zero blanking and an anode-off guard band at each slot start.
module seg7_scan_driver
    import seg7_pkg::*;
#(
    parameter int DIGITS       = 4,
    parameter int SCAN_DIV     = 50000,
    parameter int BLANK_CYC    = 8,
    parameter int BLINK_FRAMES = 64
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    input  logic [DIGITS-1:0]     dp_in,
    input  logic [DIGITS-1:0]     blink_en,
    input  logic                  hex_mode,
    input  logic                  lz_blank,
    output logic [6:0]            seg,
    output logic                  dp,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_tick
);

    localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [PW-1:0]         presc_q, presc_d;
    logic [IW-1:0]         idx_q, idx_d;
    logic [FW-1:0]         frame_q, frame_d;
    logic                  blink_q, blink_d;
    logic [4*DIGITS-1:0]   pend_val_q, pend_val_d, act_val_q, act_val_d;
    logic [DIGITS-1:0]     pend_dp_q, pend_dp_d, act_dp_q, act_dp_d;
    logic [DIGITS-1:0]     pend_blk_q, pend_blk_d, act_blk_q, act_blk_d;
    logic [6:0]            seg_q, seg_d;
    logic                  dp_q, dp_d;
    logic [DIGITS-1:0]     an_q, an_d;
    logic                  tick_q, tick_d;

    logic                  slot_end, wrap;
    logic [3:0]            cur_nib;
    logic                  cur_dp, cur_blk, cur_zero;
    logic [DIGITS-1:0]     zero_from;
    logic [6:0]            dec_seg;
    logic                  dec_blank;

    seg7_hex_decode u_dec (
        .nibble   (cur_nib),
        .hex_mode (hex_mode),
        .seg      (dec_seg),
        .blank    (dec_blank)
    );

    // Scan timing, buffer transfer and blink phase
    always_comb begin
        slot_end   = (presc_q == PW'(SCAN_DIV - 1));
        wrap       = slot_end && (idx_q == IW'(DIGITS - 1));
        presc_d    = slot_end ? '0 : presc_q + PW'(1);
        idx_d      = idx_q;
        frame_d    = frame_q;
        blink_d    = blink_q;
        pend_val_d = load ? value    : pend_val_q;
        pend_dp_d  = load ? dp_in    : pend_dp_q;
        pend_blk_d = load ? blink_en : pend_blk_q;
        act_val_d  = act_val_q;
        act_dp_d   = act_dp_q;
        act_blk_d  = act_blk_q;
        if (slot_end) begin
            idx_d = wrap ? '0 : idx_q + IW'(1);
        end else begin
            idx_d = idx_q;
        end
        if (wrap) begin
            // A load on the boundary cycle bypasses pending so it shows this frame
            act_val_d = pend_val_d;
            act_dp_d  = pend_dp_d;
            act_blk_d = pend_blk_d;
            if (frame_q == FW'(BLINK_FRAMES - 1)) begin
                frame_d = '0;
                blink_d = ~blink_q;
            end else begin
                frame_d = frame_q + FW'(1);
                blink_d = blink_q;
            end
        end else begin
            act_val_d = act_val_q;
        end
    end

    // Current-digit selection, leading-zero detection and pin values
    always_comb begin
        logic above;
        above    = 1'b1;
        cur_nib  = 4'h0;
        cur_dp   = 1'b0;
        cur_blk  = 1'b0;
        cur_zero = 1'b0;
        zero_from = '0;
        an_d     = '1;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            above        = above && (act_val_q[4*k +: 4] == 4'h0);
            zero_from[k] = above;
        end
        for (int k = 0; k < DIGITS; k++) begin
            if (IW'(k) == idx_q) begin
                cur_nib  = act_val_q[4*k +: 4];
                cur_dp   = act_dp_q[k];
                cur_blk  = act_blk_q[k];
                cur_zero = zero_from[k];
                an_d[k]  = (presc_q < PW'(BLANK_CYC));
            end else begin
                an_d[k]  = 1'b1;
            end
        end
        if (dec_blank || (lz_blank && (idx_q != '0) && cur_zero) || (cur_blk && blink_q)) begin
            seg_d = SEG_BLANK;
            dp_d  = 1'b1;
        end else begin
            seg_d = dec_seg;
            dp_d  = ~cur_dp;
        end
        tick_d = wrap;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            presc_q    <= '0;
            idx_q      <= '0;
            frame_q    <= '0;
            blink_q    <= 1'b0;
            pend_val_q <= '0;
            pend_dp_q  <= '0;
            pend_blk_q <= '0;
            act_val_q  <= '0;
            act_dp_q   <= '0;
            act_blk_q  <= '0;
            seg_q      <= SEG_BLANK;
            dp_q       <= 1'b1;
            an_q       <= '1;
            tick_q     <= 1'b0;
        end else begin
            presc_q    <= presc_d;
            idx_q      <= idx_d;
            frame_q    <= frame_d;
            blink_q    <= blink_d;
            pend_val_q <= pend_val_d;
            pend_dp_q  <= pend_dp_d;
            pend_blk_q <= pend_blk_d;
            act_val_q  <= act_val_d;
            act_dp_q   <= act_dp_d;
            act_blk_q  <= act_blk_d;
            seg_q      <= seg_d;
            dp_q       <= dp_d;
            an_q       <= an_d;
            tick_q     <= tick_d;
        end
    end

    assign seg        = seg_q;
    assign dp         = dp_q;
    assign an         = an_q;
    assign frame_tick = tick_q;

endmodule
